conware_multigen: RTL and testbench
===================================

Name: conware_multigen

Overview:
Parametrised successor to the single-step AXI-stream Life core. It accepts one WIDTH x HEIGHT frame of colour pixels on S_AXIS and converts it to cell states. It then advances the board by a run-time number of generations (one per clock), with optional toroidal wrap, and streams the result out on M_AXIS using run-time colours. It sits between the VDMA read and write channels; reported status includes frame-framing errors and a frame count.

Parameters:
DWIDTH, 32, pixel/stream data width
WIDTH, 32, board columns (>=3)
HEIGHT, 32, board rows (>=3)
GEN_W, 8, width of generation-count input
FCNT_W, 16, width of frame counter

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; one clock; reset is asynchronous and active-high
alive_color  in  DWIDTH  output colour for live cells; also the input compare value
dead_color  in  DWIDTH  output colour for dead cells
generations  in  GEN_W  generations per frame; 0 = pass-through
wrap_en  in  1  1 = toroidal edges, 0 = cells outside board dead
S_AXIS_TVALID  in  1  input beat valid
S_AXIS_TREADY  out  1  input beat ready
S_AXIS_TDATA  in  DWIDTH  input pixel
S_AXIS_TLAST  in  1  end of input frame
M_AXIS_TVALID  out  1  output beat valid
M_AXIS_TREADY  in  1  output beat ready
M_AXIS_TDATA  out  DWIDTH  output pixel
M_AXIS_TLAST  out  1  last output beat of frame
busy  out  1  high in any state but RX-idle
err_short  out  1  sticky: TLAST before N beats
err_long  out  1  sticky: N beats without TLAST
frame_count  out  FCNT_W  frames fully transmitted, wraps

Behaviour:
- N = WIDTH*HEIGHT. Cell index = row*WIDTH+col. Raster order; beat 0 = cell 0 in and out.
- Cell state is a register board[N-1:0]. A beat makes its cell alive iff TDATA == alive_color; any other value makes it dead.
- Reset (async, ARESET=1): state RX, board=0, beat counter=0, gen counter=0, S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, busy=0, err_short=0, err_long=0, frame_count=0.
  - Reset mid-frame discards all partial data.
  - S_AXIS_TREADY rises the first cycle after reset deasserts.
- States: RX, DRAIN, COMPUTE, TX.
- RX:
  - TREADY=1; each handshake writes board[cnt] and increments cnt.
  - generations, wrap_en, alive_color and dead_color are latched on the first beat of the frame (cnt==0). They are used for the whole frame; input changes mid-frame have no effect.
  - TLAST with cnt<N-1: cells cnt+1..N-1 forced dead, err_short set, go to COMPUTE.
  - Beat N-1 with TLAST: go to COMPUTE.
  - Beat N-1 without TLAST: err_long set, go to DRAIN.
- DRAIN: TREADY=1, beats are discarded until a TLAST handshake, then go to COMPUTE.
- COMPUTE:
  - TREADY=0. Each cycle: board <= step(board), gen counter++.
  - Exits to TX after exactly the latched generation count of cycles; 0 = skip directly to TX on the next cycle.
  - Latency, final input handshake to first M_AXIS_TVALID: generations+1 cycles.
- Life rule (B3/S23):
  - A live cell survives with 2 or 3 live neighbours; a dead cell is born with exactly 3.
  - Neighbour sum is 4 bits, 0..8.
  - With wrap_en=0, out-of-board neighbours count 0; with wrap_en=1, indices wrap modulo WIDTH/HEIGHT.
- TX:
  - M_AXIS_TVALID=1; TDATA = board[cnt] ? latched alive : latched dead; TLAST = (cnt==N-1).
  - TDATA, TLAST and TVALID are registered and held stable while TREADY=0.
  - Throughput is 1 beat/clock when TREADY is held high.
  - The last handshake increments frame_count and returns to RX with cnt=0 and TVALID low the next cycle.
- Error flags clear only on reset.
- No overlap: the next frame is not accepted until TX completes.

Decomposition:
- Package conware_pkg holds:
  - the state enum (RX, DRAIN, COMPUTE, TX);
  - constant N;
  - function clog2 for the counter width (clog2(N)).
- Sub-module conware_step(WIDTH, HEIGHT) is purely combinational: inputs cells_in and wrap_en, output cells_out, with the neighbour-count logic for one generation.
- The top level holds the FSM, counters, board register, colour mapping and AXI handshakes.

Test Plan:
- Blinker, 8x8 override: 3 live cells, row 3, cols 2-4; generations=1, wrap_en=0 -> live at col 3, rows 2-4; same board for generations=2; TLAST on beat 63 only; frame_count=1.
- Glider, 8x8: standard glider at top-left, wrap_en=1, generations=32 -> output identical to input; with wrap_en=0, generations=32 -> output differs; glider leaves the board or collapses.
- Pass-through: generations=0, random alive/dead pattern with non-matching pixel values -> non-alive pixels output as dead_color; first TVALID 1 cycle after last input beat.
- Short frame: TLAST on beat 10 -> err_short=1, cells 11..63 dead, 64 output beats emitted; next frame processes normally.
- Long frame: 70 beats, TLAST on beat 69 -> err_long=1, beats 64-69 accepted and discarded, output uses beats 0-63.
- Backpressure/reset: random M_AXIS_TREADY (50%) -> TDATA/TLAST stable while stalled, 64 beats, correct data. ARESET asserted mid-TX -> all outputs are their reset values immediately; a new frame after release is processed correctly.

Source files
------------

// File: rtl/conware_pkg.sv
// rtl/conware_pkg.sv - shared types, constants and helpers for the multi-generation Life core
package conware_pkg;

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_TX      = 2'd3
    } state_t;

    // Default board geometry; the top level recomputes its own cell count from its parameters
    localparam int WIDTH_DEF  = 32;
    localparam int HEIGHT_DEF = 32;
    localparam int N          = WIDTH_DEF * HEIGHT_DEF;

    // Bits needed to index value entries (never less than one bit)
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/conware_step.sv
// rtl/conware_step.sv - combinational single-generation B3/S23 update of the whole board
module conware_step
    import conware_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic [WIDTH*HEIGHT-1:0] cells_in,
    input  logic                    wrap_en,
    output logic [WIDTH*HEIGHT-1:0] cells_out
);

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            // Wrapped neighbour coordinates; edge flags decide whether the wrapped cell counts
            localparam int  RU  = (r == 0) ? HEIGHT - 1 : r - 1;
            localparam int  RD  = (r == HEIGHT - 1) ? 0 : r + 1;
            localparam int  CL  = (c == 0) ? WIDTH - 1 : c - 1;
            localparam int  CR  = (c == WIDTH - 1) ? 0 : c + 1;
            localparam bit  TOP = (r == 0);
            localparam bit  BOT = (r == HEIGHT - 1);
            localparam bit  LFT = (c == 0);
            localparam bit  RGT = (c == WIDTH - 1);

            logic [7:0] nb;
            logic [3:0] sum;

            assign nb[0] = cells_in[RU*WIDTH + CL] & (wrap_en | !(TOP || LFT));
            assign nb[1] = cells_in[RU*WIDTH + c ] & (wrap_en | !TOP);
            assign nb[2] = cells_in[RU*WIDTH + CR] & (wrap_en | !(TOP || RGT));
            assign nb[3] = cells_in[r*WIDTH  + CL] & (wrap_en | !LFT);
            assign nb[4] = cells_in[r*WIDTH  + CR] & (wrap_en | !RGT);
            assign nb[5] = cells_in[RD*WIDTH + CL] & (wrap_en | !(BOT || LFT));
            assign nb[6] = cells_in[RD*WIDTH + c ] & (wrap_en | !BOT);
            assign nb[7] = cells_in[RD*WIDTH + CR] & (wrap_en | !(BOT || RGT));

            assign sum = 4'($countones(nb));
            assign cells_out[r*WIDTH + c] = (sum == 4'd3) | (cells_in[r*WIDTH + c] & (sum == 4'd2));
        end
    end

endmodule

// File: rtl/conware_multigen.sv
// rtl/conware_multigen.sv - stream-in frame, run N Life generations, stream-out recoloured frame
module conware_multigen
    import conware_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int GEN_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DWIDTH-1:0] alive_color,
    input  logic [DWIDTH-1:0] dead_color,
    input  logic [GEN_W-1:0]  generations,
    input  logic              wrap_en,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [DWIDTH-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DWIDTH-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              busy,
    output logic              err_short,
    output logic              err_long,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int                NCELLS = WIDTH * HEIGHT;
    localparam int                CNT_W  = clog2(NCELLS);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(NCELLS - 1);

    state_t              state;
    logic [NCELLS-1:0]   board;
    logic [NCELLS-1:0]   board_step;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [GEN_W-1:0]    gen_cnt;
    logic [GEN_W-1:0]    gen_lat;
    logic                wrap_lat;
    logic [DWIDTH-1:0]   alive_lat;
    logic [DWIDTH-1:0]   dead_lat;
    logic                s_hs;
    logic                m_hs;
    logic                pix_alive;

    assign s_hs    = S_AXIS_TVALID & S_AXIS_TREADY;
    assign m_hs    = M_AXIS_TVALID & M_AXIS_TREADY;
    assign cnt_inc = cnt + CNT_W'(1);
    // Beat 0 is compared against the live input because the latch happens on that same edge
    assign pix_alive = (S_AXIS_TDATA == ((cnt == '0) ? alive_color : alive_lat));
    assign busy      = (state != ST_RX);

    conware_step #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_step (
        .cells_in  (board),
        .wrap_en   (wrap_lat),
        .cells_out (board_step)
    );

    // Frame FSM: receive/drain input, iterate generations, then transmit with registered outputs
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= ST_RX;
            board         <= '0;
            cnt           <= '0;
            gen_cnt       <= '0;
            gen_lat       <= '0;
            wrap_lat      <= 1'b0;
            alive_lat     <= '0;
            dead_lat      <= '0;
            S_AXIS_TREADY <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
            frame_count   <= '0;
        end else begin
            case (state)
                ST_RX: begin
                    S_AXIS_TREADY <= 1'b1;
                    if (s_hs) begin
                        if (cnt == '0) begin
                            // Clearing on beat 0 leaves every cell a short frame never reaches dead
                            gen_lat   <= generations;
                            wrap_lat  <= wrap_en;
                            alive_lat <= alive_color;
                            dead_lat  <= dead_color;
                            board     <= '0;
                            board[0]  <= pix_alive;
                        end else begin
                            board[cnt] <= pix_alive;
                        end
                        if (S_AXIS_TLAST) begin
                            if (cnt != LAST) begin
                                err_short <= 1'b1;
                            end
                            state         <= ST_COMPUTE;
                            S_AXIS_TREADY <= 1'b0;
                            cnt           <= '0;
                            gen_cnt       <= '0;
                        end else if (cnt == LAST) begin
                            err_long <= 1'b1;
                            state    <= ST_DRAIN;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_hs && S_AXIS_TLAST) begin
                        state         <= ST_COMPUTE;
                        S_AXIS_TREADY <= 1'b0;
                        gen_cnt       <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (gen_cnt == gen_lat) begin
                        state         <= ST_TX;
                        cnt           <= '0;
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= board[0] ? alive_lat : dead_lat;
                        M_AXIS_TLAST  <= (LAST == '0);
                    end else begin
                        board   <= board_step;
                        gen_cnt <= gen_cnt + GEN_W'(1);
                    end
                end
                ST_TX: begin
                    if (m_hs) begin
                        if (cnt == LAST) begin
                            state         <= ST_RX;
                            cnt           <= '0;
                            M_AXIS_TVALID <= 1'b0;
                            M_AXIS_TLAST  <= 1'b0;
                            S_AXIS_TREADY <= 1'b1;
                            frame_count   <= frame_count + FCNT_W'(1);
                        end else begin
                            cnt          <= cnt_inc;
                            M_AXIS_TDATA <= board[cnt_inc] ? alive_lat : dead_lat;
                            M_AXIS_TLAST <= (cnt_inc == LAST);
                        end
                    end
                end
                default: state <= ST_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_conware_multigen.sv
// tb/tb_conware_multigen.sv - directed self-checking bench for conware_multigen on an 8x8 board
module tb_conware_multigen;

    localparam logic [31:0] ALIVE = 32'h00FF_A5A5;
    localparam logic [31:0] DEAD  = 32'h1234_5678;

    localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] GLIDER   = 64'h0000_0000_0007_0402;
    localparam logic [63:0] GLIDER_4 = 64'h0000_0000_0E08_0400;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] alive_color = ALIVE;
    logic [31:0] dead_color = DEAD;
    logic [7:0]  generations = 8'd0;
    logic        wrap_en = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        S_AXIS_TREADY;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        M_AXIS_TVALID;
    logic        m_tready = 1'b0;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        busy;
    logic        err_short;
    logic        err_long;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;

    conware_multigen #(
        .DWIDTH (32),
        .WIDTH  (8),
        .HEIGHT (8),
        .GEN_W  (8),
        .FCNT_W (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .alive_color   (alive_color),
        .dead_color    (dead_color),
        .generations   (generations),
        .wrap_en       (wrap_en),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TLAST  (s_tlast),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (m_tready),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .busy          (busy),
        .err_short     (err_short),
        .err_long      (err_long),
        .frame_count   (frame_count)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [63:0] pat, input int nbeats, input int last_beat,
                              input logic [7:0] gen, input logic wrap, input bit swap);
        int  t;
        logic bit_alive;
        generations = gen;
        wrap_en     = wrap;
        for (int i = 0; i < nbeats; i++) begin
            t         = 0;
            bit_alive = (i < 64) ? pat[i % 64] : 1'b1;
            s_tvalid  = 1'b1;
            s_tdata   = bit_alive ? ALIVE : (ALIVE ^ ($urandom() | 32'h1));
            s_tlast   = (i == last_beat);
            while (!S_AXIS_TREADY && t < 200) begin
                @(posedge ACLK);
                #1;
                t++;
            end
            check("send_tready", S_AXIS_TREADY, 1);
            @(posedge ACLK);
            #1;
            if (swap && i == 0) begin
                alive_color = 32'hDEAD_BEEF;
                dead_color  = 32'h0BAD_F00D;
                generations = 8'd5;
                wrap_en     = ~wrap;
            end
        end
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        last_hs_cyc = cyc;
        alive_color = ALIVE;
        dead_color  = DEAD;
    endtask

    task automatic recv_frame(input string tag, input bit rnd, output logic [63:0] got,
                              output int first_cyc);
        int          beats;
        int          t;
        int          bad;
        int          nlast;
        int          lastpos;
        int          unstable;
        bit          stalled;
        logic [31:0] pd;
        logic        pl;
        beats = 0; t = 0; bad = 0; nlast = 0; lastpos = -1; unstable = 0;
        stalled = 1'b0; pd = '0; pl = 1'b0; got = '0; first_cyc = -1;
        while (beats < 64 && t < 3000) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ACLK);
            if (M_AXIS_TVALID) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled && (M_AXIS_TDATA !== pd || M_AXIS_TLAST !== pl)) unstable++;
                if (m_tready) begin
                    if (M_AXIS_TDATA == ALIVE) got[beats] = 1'b1;
                    else if (M_AXIS_TDATA != DEAD) bad++;
                    if (M_AXIS_TLAST) begin
                        nlast++;
                        lastpos = beats;
                    end
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd      = M_AXIS_TDATA;
                    pl      = M_AXIS_TLAST;
                end
            end
            @(posedge ACLK);
            #1;
            t++;
        end
        m_tready = 1'b0;
        check({tag, "_beats"}, beats, 64);
        check({tag, "_bad_colour"}, bad, 0);
        check({tag, "_tlast_count"}, nlast, 1);
        check({tag, "_tlast_pos"}, lastpos, 63);
        check({tag, "_stable"}, unstable, 0);
    endtask

    task automatic run_case(input string tag, input logic [63:0] pat, input int nbeats,
                            input int last_beat, input logic [7:0] gen, input logic wrap,
                            input bit swap, input bit rnd, input logic [63:0] exp, input int exp_lat);
        logic [63:0] got;
        int          fc;
        send_frame(pat, nbeats, last_beat, gen, wrap, swap);
        check({tag, "_busy"}, busy, 1);
        recv_frame(tag, rnd, got, fc);
        check({tag, "_board"}, got, exp);
        if (exp_lat >= 0) check({tag, "_latency"}, fc - last_hs_cyc, exp_lat);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, S_AXIS_TREADY, 0);
        check({tag, "_tvalid"}, M_AXIS_TVALID, 0);
        check({tag, "_tdata"}, M_AXIS_TDATA, 0);
        check({tag, "_tlast"}, M_AXIS_TLAST, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_short"}, err_short, 0);
        check({tag, "_err_long"}, err_long, 0);
        check({tag, "_frame_count"}, frame_count, 0);
    endtask

    initial begin
        logic [63:0] rpat;
        logic [63:0] got;
        int          fc;

        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        ARESET = 1'b0;
        check("reset_release_tready", S_AXIS_TREADY, 0);
        @(posedge ACLK);
        #1;
        check("first_cycle_tready", S_AXIS_TREADY, 1);

        run_case("blinker_g1", BLINK_H, 64, 63, 8'd1, 1'b0, 0, 0, BLINK_V, 2);
        check("blinker_g1_fcount", frame_count, 1);
        run_case("blinker_g2", BLINK_H, 64, 63, 8'd2, 1'b0, 0, 0, BLINK_H, 3);
        check("blinker_g2_fcount", frame_count, 2);

        run_case("glider_wrap_g32", GLIDER, 64, 63, 8'd32, 1'b1, 0, 0, GLIDER, 33);
        send_frame(GLIDER, 64, 63, 8'd32, 1'b0, 0);
        recv_frame("glider_nowrap_g32", 0, got, fc);
        check("glider_nowrap_differs", (got != GLIDER), 1);

        rpat = {$urandom(), $urandom()};
        run_case("passthru", rpat, 64, 63, 8'd0, 1'b0, 1, 0, rpat, 1);

        run_case("short", 64'h0000_0000_0000_07FF, 11, 10, 8'd0, 1'b0, 0, 0,
                 64'h0000_0000_0000_07FF, 1);
        check("short_err_short", err_short, 1);
        check("short_err_long", err_long, 0);
        run_case("after_short", BLINK_H, 64, 63, 8'd1, 1'b0, 0, 0, BLINK_V, 2);

        rpat = {$urandom(), $urandom()};
        run_case("long", rpat, 70, 69, 8'd0, 1'b0, 0, 0, rpat, 1);
        check("long_err_long", err_long, 1);

        run_case("backpressure", GLIDER, 64, 63, 8'd4, 1'b1, 0, 1, GLIDER_4, -1);
        check("backpressure_fcount", frame_count, 9);

        rpat = {$urandom(), $urandom()};
        send_frame(rpat, 64, 63, 8'd0, 1'b0, 0);
        m_tready = 1'b1;
        repeat (5) @(posedge ACLK);
        #3;
        ARESET = 1'b1;
        #1;
        check_reset_outputs("mid_tx_reset");
        m_tready = 1'b0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        check("mid_tx_release_tready", S_AXIS_TREADY, 0);
        @(posedge ACLK);
        #1;
        check("mid_tx_first_cycle_tready", S_AXIS_TREADY, 1);
        run_case("after_reset", BLINK_H, 64, 63, 8'd1, 1'b0, 0, 0, BLINK_V, 2);
        check("after_reset_fcount", frame_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
